fp_mul_pp_reduce: RTL and testbench

- Downstream consumer of the multiplier's partial-product pipeline register.
- Takes the 13 registered radix-4 Booth partial products (26 bits each) plus the two original IEEE-754 single operands.
- Iteratively sums the partial products into a 48-bit mantissa product, then handles normalisation, round-to-nearest-even, exponent and special cases.
- Emits a 32-bit float result through a valid/ready handshake.

---
 rtl/fp_mul_pkg.sv | 55 +++++
 rtl/fp_mul_pp_reduce_if.sv | 35 +++
 rtl/fp_round_pack.sv | 69 ++++++
 rtl/fp_mul_pp_reduce.sv | 135 +++++++++++++
 tb/tb_fp_mul_pp_reduce.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/fp_mul_pkg.sv
// -----------------------------------------------------------------------------
// fp_mul_pkg
// Shared definitions for the single-precision multiplier back end:
// IEEE-754 field widths, Booth partial-product geometry, the reduce FSM
// state encoding, special-operand classes and the flag bit positions.
// -----------------------------------------------------------------------------
package fp_mul_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int PP_COUNT = 13;
    localparam int PP_W     = 26;
    localparam int ACC_W    = 48;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Bit positions inside flags = {invalid, overflow, underflow, inexact}
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        NORM,
        ROUND,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        SPC_NONE,
        SPC_NAN,
        SPC_INF,
        SPC_ZERO
    } spc_t;

    // Operand classification (sign bits excluded). Exponent 0 is treated as
    // zero, so subnormal inputs are flushed.
    function automatic spc_t classify(input logic [30:0] a, input logic [30:0] b);
        logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return SPC_NAN;
        if (a_inf || b_inf)                                       return SPC_INF;
        if (a_zero || b_zero)                                     return SPC_ZERO;
        return SPC_NONE;
    endfunction

endpackage

// File: rtl/fp_mul_pp_reduce_if.sv
// -----------------------------------------------------------------------------
// fp_mul_pp_reduce_if
// Handshake bundle between the Booth partial-product stage, the reduce block
// and the result consumer.
//   in_valid/in_ready   : input transfer handshake
//   pp_bus              : PP_COUNT x PP_W two's-complement partial products
//   in_a/in_b           : original IEEE single operands
//   result/flags        : packed product and {invalid, overflow, underflow, inexact}
//   out_valid/out_ready : output transfer handshake
// master = producer/consumer side, slave = reduce block.
// -----------------------------------------------------------------------------
interface fp_mul_pp_reduce_if;
    import fp_mul_pkg::*;

    logic                         in_valid;
    logic                         in_ready;
    logic [PP_COUNT*PP_W-1:0]     pp_bus;
    logic [31:0]                  in_a;
    logic [31:0]                  in_b;
    logic [31:0]                  result;
    logic [3:0]                   flags;
    logic                         out_valid;
    logic                         out_ready;

    modport master (
        output in_valid, pp_bus, in_a, in_b, out_ready,
        input  in_ready, result, flags, out_valid
    );

    modport slave (
        input  in_valid, pp_bus, in_a, in_b, out_ready,
        output in_ready, result, flags, out_valid
    );

endinterface

// File: rtl/fp_round_pack.sv
// -----------------------------------------------------------------------------
// fp_round_pack
// Combinational round-to-nearest-even and IEEE single packing.
//   i_sign   : result sign
//   i_exp    : signed biased exponent before rounding
//   i_frac   : 23 fraction bits kept after normalisation
//   i_g/i_s  : guard bit and sticky OR of everything below it
//   i_spc    : special-operand class (overrides the numeric path)
//   o_result : packed IEEE single
//   o_flags  : {invalid, overflow, underflow, inexact}
// Shared with the adder path, so it knows nothing about partial products.
// -----------------------------------------------------------------------------
module fp_round_pack
    import fp_mul_pkg::*;
(
    input  logic                    i_sign,
    input  logic signed [9:0]       i_exp,
    input  logic [FRAC_W-1:0]       i_frac,
    input  logic                    i_g,
    input  logic                    i_s,
    input  spc_t                    i_spc,
    output logic [31:0]             o_result,
    output logic [3:0]              o_flags
);

    function automatic logic round_up(input logic lsb, input logic g, input logic s);
        return g & (s | lsb);
    endfunction

    logic [FRAC_W:0]   w_mant;
    logic signed [9:0] w_exp;

    // A carry out of the fraction means 1.111..1 rounded to 10.000..0; the low
    // bits of w_mant are then already zero, only the exponent moves.
    assign w_mant = {1'b0, i_frac} + (FRAC_W+1)'(round_up(i_frac[0], i_g, i_s));
    assign w_exp  = i_exp + $signed({9'd0, w_mant[FRAC_W]});

    always_comb begin
        o_result = '0;
        o_flags  = '0;
        case (i_spc)
            SPC_NAN: begin
                o_result               = QNAN;
                o_flags[FLAG_INVALID]  = 1'b1;
            end
            SPC_INF: begin
                o_result = {i_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            end
            SPC_ZERO: begin
                o_result = {i_sign, {(EXP_W+FRAC_W){1'b0}}};
            end
            default: begin
                if (w_exp >= 10'sd255) begin
                    o_result                 = {i_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    o_flags[FLAG_OVERFLOW]   = 1'b1;
                    o_flags[FLAG_INEXACT]    = 1'b1;
                end else if (w_exp <= 10'sd0) begin
                    o_result                 = {i_sign, {(EXP_W+FRAC_W){1'b0}}};
                    o_flags[FLAG_UNDERFLOW]  = 1'b1;
                    o_flags[FLAG_INEXACT]    = 1'b1;
                end else begin
                    o_result                 = {i_sign, w_exp[EXP_W-1:0], w_mant[FRAC_W-1:0]};
                    o_flags[FLAG_INEXACT]    = i_g | i_s;
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_mul_pp_reduce.sv
// -----------------------------------------------------------------------------
// fp_mul_pp_reduce
// Sums the 13 registered radix-4 Booth partial products one per cycle into a
// 48-bit mantissa product, normalises, rounds (RNE) and emits the IEEE single
// product with flags. Fixed latency: accept at edge N, out_valid from N+15.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, aborts any operation in flight
//   bus  : fp_mul_pp_reduce_if.slave (input/output handshakes, data)
// -----------------------------------------------------------------------------
module fp_mul_pp_reduce #(
    parameter int PP_COUNT = 13,
    parameter int PP_W     = 26,
    parameter int ACC_W    = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    fp_mul_pp_reduce_if.slave     bus
);
    import fp_mul_pkg::*;

    state_t                      r_state;
    state_t                      w_state_nxt;

    logic [PP_COUNT*PP_W-1:0]    r_pp;
    logic [31:0]                 r_a;
    logic [31:0]                 r_b;
    logic [ACC_W-1:0]            r_acc;
    logic [3:0]                  r_idx;

    logic                        r_sign;
    logic signed [9:0]           r_exp;
    logic [FRAC_W-1:0]           r_frac;
    logic                        r_g;
    logic                        r_s;
    spc_t                        r_spc;

    logic [31:0]                 r_result;
    logic [3:0]                  r_flags;

    logic signed [PP_W-1:0]      w_pp;
    logic [ACC_W-1:0]            w_term;
    logic signed [9:0]           w_exp_norm;
    logic [31:0]                 w_result;
    logic [3:0]                  w_flags;

    // Partial product idx carries weight 4^idx: sign-extend, then shift by 2*idx.
    assign w_pp   = r_pp[r_idx*PP_W +: PP_W];
    assign w_term = {{(ACC_W-PP_W){w_pp[PP_W-1]}}, w_pp} << {r_idx, 1'b0};

    // Product of two [1,2) mantissas lies in [1,4); the top bit says which.
    assign w_exp_norm = $signed({2'b00, r_a[30:23]}) + $signed({2'b00, r_b[30:23]})
                      - $signed(10'(EXP_BIAS)) + $signed({9'd0, r_acc[ACC_W-1]});

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)                   w_state_nxt = ACCUM;
            ACCUM:   if (r_idx == 4'(PP_COUNT-1))        w_state_nxt = NORM;
            NORM:                                        w_state_nxt = ROUND;
            ROUND:                                       w_state_nxt = DONE;
            DONE:    if (bus.out_ready)                  w_state_nxt = IDLE;
            default:                                     w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_idx    <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                // capture: latch products and operands, restart the sum
                IDLE: begin
                    if (bus.in_valid) begin
                        r_pp  <= bus.pp_bus;
                        r_a   <= bus.in_a;
                        r_b   <= bus.in_b;
                        r_acc <= '0;
                        r_idx <= '0;
                    end
                end
                // accumulate: one partial product per cycle, mod 2^ACC_W
                ACCUM: begin
                    r_acc <= r_acc + w_term;
                    r_idx <= r_idx + 4'd1;
                end
                // normalise: pick the 23 fraction bits below the leading one
                NORM: begin
                    r_sign <= r_a[31] ^ r_b[31];
                    r_exp  <= w_exp_norm;
                    r_spc  <= classify(r_a[30:0], r_b[30:0]);
                    if (r_acc[ACC_W-1]) begin
                        r_frac <= r_acc[ACC_W-2 -: FRAC_W];
                        r_g    <= r_acc[ACC_W-2-FRAC_W];
                        r_s    <= |r_acc[ACC_W-3-FRAC_W:0];
                    end else begin
                        r_frac <= r_acc[ACC_W-3 -: FRAC_W];
                        r_g    <= r_acc[ACC_W-3-FRAC_W];
                        r_s    <= |r_acc[ACC_W-4-FRAC_W:0];
                    end
                end
                // round/pack: register the final word, held through DONE
                ROUND: begin
                    r_result <= w_result;
                    r_flags  <= w_flags;
                end
                default: ;
            endcase
        end
    end

    fp_round_pack u_round_pack (
        .i_sign   (r_sign),
        .i_exp    (r_exp),
        .i_frac   (r_frac),
        .i_g      (r_g),
        .i_s      (r_s),
        .i_spc    (r_spc),
        .o_result (w_result),
        .o_flags  (w_flags)
    );

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.result    = r_result;
    assign bus.flags     = r_flags;

endmodule

// File: tb/tb_fp_mul_pp_reduce.sv
// -----------------------------------------------------------------------------
// tb_fp_mul_pp_reduce
// Drives Booth partial products built from the operands, checks every result
// against an integer IEEE multiply model, and exercises back-pressure and
// mid-operation reset.
// -----------------------------------------------------------------------------
module tb_fp_mul_pp_reduce;
    import fp_mul_pkg::*;

    logic clk = 1'b0;
    logic rst;

    fp_mul_pp_reduce_if bus_if ();

    fp_mul_pp_reduce dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Radix-4 Booth recoding of the 24-bit multiplier mantissa (zero padded to
    // 26 bits); digit_i in {-2..2}, pp_i = digit_i * mantissa_a.
    function automatic logic [PP_COUNT*PP_W-1:0] booth_pp(input logic [31:0] a, input logic [31:0] b);
        logic [PP_COUNT*PP_W-1:0] pb;
        logic [25:0]              mb;
        logic                     prev;
        longint                   ma;
        longint                   pp;
        int                       d;
        ma   = longint'({1'b1, a[22:0]});
        mb   = {2'b00, 1'b1, b[22:0]};
        prev = 1'b0;
        pb   = '0;
        for (int i = 0; i < PP_COUNT; i++) begin
            d    = -2 * int'(mb[2*i+1]) + int'(mb[2*i]) + int'(prev);
            prev = mb[2*i+1];
            pp   = longint'(d) * ma;
            pb[i*PP_W +: PP_W] = pp[PP_W-1:0];
        end
        return pb;
    endfunction

    // Reference: {flags, result} from exact integer product and RNE by remainder.
    function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic   sign, za, zb, ia, ib, na, nb;
        int     ea, eb, e;
        longint ma, mb, p, keep, rem, half;
        logic [31:0] res;
        sign = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 23'd0);
        ib = (eb == 255) && (b[22:0] == 23'd0);
        na = (ea == 255) && (a[22:0] != 23'd0);
        nb = (eb == 255) && (b[22:0] != 23'd0);
        if (na || nb || (ia && zb) || (ib && za)) return {4'b1000, 32'h7FC00000};
        if (ia || ib) return {4'b0000, sign, 8'hFF, 23'd0};
        if (za || zb) return {4'b0000, sign, 31'd0};
        ma = longint'({1'b1, a[22:0]});
        mb = longint'({1'b1, b[22:0]});
        p  = ma * mb;
        e  = ea + eb - 127;
        if (p >= (longint'(1) << 47)) begin
            e++;
            half = longint'(1) << 23;
            keep = p >> 24;
        end else begin
            half = longint'(1) << 22;
            keep = p >> 23;
        end
        rem = p % (half * 2);
        if (rem > half || (rem == half && (keep % 2) == 1)) keep++;
        if (keep == (longint'(1) << 24)) begin
            keep = keep >> 1;
            e++;
        end
        if (e >= 255) return {4'b0101, sign, 8'hFF, 23'd0};
        if (e <= 0)   return {4'b0011, sign, 31'd0};
        res = {sign, 8'(e), keep[22:0]};
        return {3'b000, (rem != 0), res};
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        int          sel;
        v   = $urandom;
        sel = $urandom_range(0, 9);
        if (sel == 0) begin
            case ($urandom_range(0, 4))
                0:       v[30:0]  = 31'd0;
                1:       begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
                2:       v[30:23] = 8'hFF;
                3:       v[30:23] = 8'h00;
                default: v[30:23] = 8'hFE;
            endcase
        end else if (sel >= 4) begin
            v[30:23] = 8'($urandom_range(90, 164));
        end
        return v;
    endfunction

    // One full transaction. hold = cycles out_ready stays low after out_valid,
    // during which in_valid is pushed high and must be ignored.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [35:0] exp_v, input int hold, input string tag);
        int lat;
        bit busy_bad;
        bit hold_bad;
        chk({tag, "_in_ready_idle"}, 32'(bus_if.in_ready), 32'd1);
        bus_if.pp_bus    = booth_pp(a, b);
        bus_if.in_a      = a;
        bus_if.in_b      = b;
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = (hold == 0);
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        lat      = 0;
        busy_bad = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus_if.out_valid) begin
                lat = k;
                break;
            end
            if (bus_if.in_ready) busy_bad = 1'b1;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd15);
        chk({tag, "_in_ready_busy"}, 32'(busy_bad), 32'd0);
        chk({tag, "_result"}, bus_if.result, exp_v[31:0]);
        chk({tag, "_flags"}, 32'(bus_if.flags), 32'(exp_v[35:32]));
        hold_bad = 1'b0;
        for (int k = 0; k < hold; k++) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_a     = $urandom;
            bus_if.in_b     = $urandom;
            @(posedge clk); #1;
            if (!bus_if.out_valid || bus_if.in_ready ||
                bus_if.result !== exp_v[31:0] || bus_if.flags !== exp_v[35:32])
                hold_bad = 1'b1;
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        if (hold > 0) chk({tag, "_hold_stable"}, 32'(hold_bad), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_release_valid"}, 32'(bus_if.out_valid), 32'd0);
        chk({tag, "_release_ready"}, 32'(bus_if.in_ready), 32'd1);
    endtask

    initial begin
        bit          abort_bad;
        logic [31:0] ra;
        logic [31:0] rb;

        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.pp_bus    = '0;
        bus_if.in_a      = '0;
        bus_if.in_b      = '0;
        bus_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready",  32'(bus_if.in_ready),  32'd1);
        chk("reset_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("reset_result",    bus_if.result,         32'd0);
        chk("reset_flags",     32'(bus_if.flags),     32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases with hand-derived expectations
        run_op(32'h3F800000, 32'h3F800000, {4'b0000, 32'h3F800000}, 0, "one_x_one");
        run_op(32'h3FC00000, 32'h3FC00000, {4'b0000, 32'h40100000}, 0, "1p5_sq");
        run_op(32'h3F800001, 32'h3F800001, {4'b0001, 32'h3F800002}, 0, "ulp_sq");
        run_op(32'h7F7FFFFF, 32'h40000000, {4'b0101, 32'h7F800000}, 0, "overflow");
        run_op(32'h7F800000, 32'h00000000, {4'b1000, 32'h7FC00000}, 0, "inf_x_zero");
        run_op(32'h00800000, 32'h00800000, {4'b0011, 32'h00000000}, 0, "underflow");
        run_op(32'h80000000, 32'h3F800000, {4'b0000, 32'h80000000}, 0, "neg_zero");
        run_op(32'h7F800000, 32'hC0000000, {4'b0000, 32'hFF800000}, 0, "inf_x_neg2");
        run_op(32'h7FC00001, 32'h3F800000, {4'b1000, 32'h7FC00000}, 0, "nan_in");
        run_op(32'h40400000, 32'h40400000, {4'b0000, 32'h41100000}, 20, "backpressure");
        run_op(32'h3F800000, 32'hC0000000, {4'b0000, 32'hC0000000}, 0, "after_hold");

        // Reset during ACCUM drops the operation
        bus_if.pp_bus   = booth_pp(32'h40400000, 32'h40000000);
        bus_if.in_a     = 32'h40400000;
        bus_if.in_b     = 32'h40000000;
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready",  32'(bus_if.in_ready),  32'd1);
        chk("abort_out_valid", 32'(bus_if.out_valid), 32'd0);
        abort_bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (bus_if.out_valid || !bus_if.in_ready) abort_bad = 1'b1;
        end
        chk("abort_no_output", 32'(abort_bad), 32'd0);
        run_op(32'h40000000, 32'h40400000, {4'b0000, 32'h40C00000}, 0, "two_x_three");

        // Randomised operands against the reference model
        for (int n = 0; n < 40; n++) begin
            ra = rand_operand();
            rb = rand_operand();
            run_op(ra, rb, ref_mul(ra, rb), $urandom_range(0, 3), $sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
